// File: rtl/ddr3_burst_scheduler.sv
// Round-robin burst scheduler sharing the DDR3 user interface between the camera
// write FIFO drain and the HDMI read FIFO refill, with ping-pong frame banks.
module ddr3_burst_scheduler #(
  parameter int unsigned           ADDR_W      = 29,
  parameter int unsigned           CNT_W       = 11,
  parameter int unsigned           RFIFO_DEPTH = 1024,
  parameter int unsigned           ADDR_STEP   = 8,
  parameter logic [ADDR_W-1:0]     BANK_OFFSET = 29'h0400000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_calib_complete,
  input  logic              wr_load,
  input  logic              rd_load,
  input  logic [ADDR_W-1:0] app_addr_wr_min,
  input  logic [ADDR_W-1:0] app_addr_wr_max,
  input  logic [ADDR_W-1:0] app_addr_rd_min,
  input  logic [ADDR_W-1:0] app_addr_rd_max,
  input  logic [7:0]        wr_bust_len,
  input  logic [7:0]        rd_bust_len,
  input  logic [CNT_W-1:0]  wfifo_rcount,
  input  logic [CNT_W-1:0]  rfifo_wcount,
  input  logic              app_rdy,
  input  logic              app_wdf_rdy,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  output logic              wfifo_rden,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic              busy
);

  typedef enum logic [1:0] {WAIT_CALIB, IDLE, WRITE, READ} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wrAddr_q, wrAddr_d, rdAddr_q, rdAddr_d;
  logic              wrBank_q, wrBank_d, rdBank_q, rdBank_d;
  logic              lastRead_q, lastRead_d;
  logic              wrPending_q, wrPending_d, rdPending_q, rdPending_d;
  logic [7:0]        burstLen_q, burstLen_d, beatCnt_q, beatCnt_d;

  logic [7:0]        wrLenEff, rdLenEff;
  logic [CNT_W:0]    rdSum;
  logic              wrReq, rdReq, wrBeat, rdBeat, lastBeat, wrBankNext;

  // Next address in the window; a beat exactly at max is legal, anything past it wraps.
  function automatic logic [ADDR_W-1:0] nextAddr(input logic [ADDR_W-1:0] addr,
                                                 input logic [ADDR_W-1:0] minAddr,
                                                 input logic [ADDR_W-1:0] maxAddr);
    logic [ADDR_W:0] sum;
    sum = {1'b0, addr} + (ADDR_W+1)'(ADDR_STEP);
    return (sum > {1'b0, maxAddr}) ? minAddr : sum[ADDR_W-1:0];
  endfunction

  assign wrLenEff = (wr_bust_len == 8'd0) ? 8'd1 : wr_bust_len;
  assign rdLenEff = (rd_bust_len == 8'd0) ? 8'd1 : rd_bust_len;
  assign wrReq    = {1'b0, wfifo_rcount} >= (CNT_W+1)'(wrLenEff);
  assign rdSum    = {1'b0, rfifo_wcount} + (CNT_W+1)'(rdLenEff);
  assign rdReq    = rdSum <= (CNT_W+1)'(RFIFO_DEPTH);
  assign wrBeat   = (state_q == WRITE) && app_rdy && app_wdf_rdy;
  assign rdBeat   = (state_q == READ) && app_rdy;
  assign lastBeat = (beatCnt_q + 8'd1) == burstLen_q;

  assign busy    = (state_q == WRITE) || (state_q == READ);
  assign wr_bank = wrBank_q;
  assign rd_bank = rdBank_q;

  always_comb begin
    state_d      = state_q;
    wrAddr_d     = wrAddr_q;
    rdAddr_d     = rdAddr_q;
    wrBank_d     = wrBank_q;
    rdBank_d     = rdBank_q;
    lastRead_d   = lastRead_q;
    wrPending_d  = wrPending_q | wr_load;
    rdPending_d  = rdPending_q | rd_load;
    burstLen_d   = burstLen_q;
    beatCnt_d    = beatCnt_q;
    wrBankNext   = wrBank_q;
    app_en       = 1'b0;
    app_cmd      = 3'b000;
    app_addr     = '0;
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    wfifo_rden   = 1'b0;

    case (state_q)
      WAIT_CALIB: begin
        if (init_calib_complete) state_d = IDLE;
      end

      IDLE: begin
        // Frame loads land only here, and the read bank follows the freshly toggled write bank.
        if (wrPending_q) begin
          wrAddr_d    = app_addr_wr_min;
          wrBankNext  = ~wrBank_q;
          wrBank_d    = wrBankNext;
          wrPending_d = wr_load;
        end
        if (rdPending_q) begin
          rdAddr_d    = app_addr_rd_min;
          rdBank_d    = ~wrBankNext;
          rdPending_d = rd_load;
        end
        if (!init_calib_complete) begin
          state_d = WAIT_CALIB;
        end else if (!wrPending_q && !rdPending_q) begin
          if (wrReq && (!rdReq || lastRead_q)) begin
            state_d    = WRITE;
            lastRead_d = 1'b0;
            burstLen_d = wrLenEff;
            beatCnt_d  = 8'd0;
          end else if (rdReq) begin
            state_d    = READ;
            lastRead_d = 1'b1;
            burstLen_d = rdLenEff;
            beatCnt_d  = 8'd0;
          end
        end
      end

      WRITE: begin
        app_addr = wrAddr_q + (wrBank_q ? BANK_OFFSET : '0);
        if (wrBeat) begin
          app_en       = 1'b1;
          app_wdf_wren = 1'b1;
          app_wdf_end  = 1'b1;
          wfifo_rden   = 1'b1;
          wrAddr_d     = nextAddr(wrAddr_q, app_addr_wr_min, app_addr_wr_max);
          beatCnt_d    = beatCnt_q + 8'd1;
          if (lastBeat) state_d = IDLE;
        end
        if (!init_calib_complete) state_d = WAIT_CALIB;
      end

      READ: begin
        app_addr = rdAddr_q + (rdBank_q ? BANK_OFFSET : '0);
        app_cmd  = 3'b001;
        if (rdBeat) begin
          app_en    = 1'b1;
          rdAddr_d  = nextAddr(rdAddr_q, app_addr_rd_min, app_addr_rd_max);
          beatCnt_d = beatCnt_q + 8'd1;
          if (lastBeat) state_d = IDLE;
        end
        if (!init_calib_complete) state_d = WAIT_CALIB;
      end

      default: state_d = WAIT_CALIB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WAIT_CALIB;
      wrAddr_q    <= app_addr_wr_min;
      rdAddr_q    <= app_addr_rd_min;
      wrBank_q    <= 1'b0;
      rdBank_q    <= 1'b1;
      lastRead_q  <= 1'b1;
      wrPending_q <= 1'b0;
      rdPending_q <= 1'b0;
      burstLen_q  <= 8'd1;
      beatCnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      wrAddr_q    <= wrAddr_d;
      rdAddr_q    <= rdAddr_d;
      wrBank_q    <= wrBank_d;
      rdBank_q    <= rdBank_d;
      lastRead_q  <= lastRead_d;
      wrPending_q <= wrPending_d;
      rdPending_q <= rdPending_d;
      burstLen_q  <= burstLen_d;
      beatCnt_q   <= beatCnt_d;
    end
  end

endmodule

// File: tb/tb_ddr3_burst_scheduler.sv
// Directed bench for ddr3_burst_scheduler: calibration gate, bursts, stalls,
// round-robin arbitration, address wrap, deferred frame loads, read space and reset.
module tb_ddr3_burst_scheduler;

  localparam int unsigned       ADDR_W      = 29;
  localparam int unsigned       CNT_W       = 11;
  localparam int unsigned       RFIFO_DEPTH = 1024;
  localparam logic [ADDR_W-1:0] BANK_OFF    = 29'h0400000;
  localparam logic [ADDR_W-1:0] WR_MIN      = 29'h0000000;
  localparam logic [ADDR_W-1:0] WR_MAX      = 29'h0001000;
  localparam logic [ADDR_W-1:0] RD_MIN      = 29'h0002000;
  localparam logic [ADDR_W-1:0] RD_MAX      = 29'h0003000;

  logic              clk = 1'b0;
  logic              reset, init_calib_complete, wr_load, rd_load;
  logic [ADDR_W-1:0] app_addr_wr_min, app_addr_wr_max, app_addr_rd_min, app_addr_rd_max;
  logic [7:0]        wr_bust_len, rd_bust_len;
  logic [CNT_W-1:0]  wfifo_rcount, rfifo_wcount;
  logic              app_rdy, app_wdf_rdy;
  logic              app_en, app_wdf_wren, app_wdf_end, wfifo_rden, wr_bank, rd_bank, busy;
  logic [2:0]        app_cmd;
  logic [ADDR_W-1:0] app_addr;

  int vectors = 0;
  int miscompares = 0;

  logic [ADDR_W-1:0] addrQ[$];
  logic [2:0]        cmdQ[$];
  int                rdenCnt, endCnt, stallCnt;

  ddr3_burst_scheduler dut (
    .clk(clk), .reset(reset), .init_calib_complete(init_calib_complete),
    .wr_load(wr_load), .rd_load(rd_load),
    .app_addr_wr_min(app_addr_wr_min), .app_addr_wr_max(app_addr_wr_max),
    .app_addr_rd_min(app_addr_rd_min), .app_addr_rd_max(app_addr_rd_max),
    .wr_bust_len(wr_bust_len), .rd_bust_len(rd_bust_len),
    .wfifo_rcount(wfifo_rcount), .rfifo_wcount(rfifo_wcount),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .wfifo_rden(wfifo_rden),
    .wr_bank(wr_bank), .rd_bank(rd_bank), .busy(busy)
  );

  always #5 clk = ~clk;

  // One reset cycle; returns at the falling edge right after it with reset released.
  task automatic doReset();
    @(negedge clk);
    reset   = 1'b1;
    wr_load = 1'b0;
    rd_load = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Records every accepted command; without holdReqs the FIFO requests drop once a burst starts.
  task automatic collect(input int cycles, input bit holdReqs, input logic [63:0] rdyPat);
    addrQ.delete();
    cmdQ.delete();
    rdenCnt  = 0;
    endCnt   = 0;
    stallCnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (app_en) begin
        addrQ.push_back(app_addr);
        cmdQ.push_back(app_cmd);
      end
      if (wfifo_rden) rdenCnt++;
      if (app_wdf_end) endCnt++;
      if (busy && !app_en) stallCnt++;
      if (busy && !holdReqs) begin
        wfifo_rcount = '0;
        rfifo_wcount = CNT_W'(RFIFO_DEPTH);
      end
      app_wdf_rdy = rdyPat[i];
    end
    app_wdf_rdy = 1'b1;
  endtask

  task automatic test_reset();
    init_calib_complete = 1'b0;
    wfifo_rcount = 11'd64;
    doReset();
    vectors++;
    if (app_en !== 1'b0 || wfifo_rden !== 1'b0 || app_wdf_wren !== 1'b0 || app_cmd !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_strobes: got en=%b rden=%b wren=%b cmd=%b, want 0 0 0 000",
               app_en, wfifo_rden, app_wdf_wren, app_cmd);
    end
    vectors++;
    if (wr_bank !== 1'b0 || rd_bank !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_banks: got wr_bank=%b rd_bank=%b busy=%b, want 0 1 0", wr_bank, rd_bank, busy);
    end
  endtask

  task automatic test_calib_gate();
    int enSeen = 0;
    init_calib_complete = 1'b0;
    wfifo_rcount = 11'd64;
    wr_bust_len  = 8'd4;
    doReset();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (app_en) enSeen++;
    end
    vectors++;
    if (enSeen !== 0) begin
      miscompares++;
      $display("[TB] FAIL calib_gate_hold: got %0d commands before calibration, want 0", enSeen);
    end
    init_calib_complete = 1'b1;
    @(negedge clk);
    vectors++;
    if (app_en !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL calib_idle_cycle: got en=%b busy=%b, want 0 0", app_en, busy);
    end
    @(negedge clk);
    vectors++;
    if (app_en !== 1'b1 || app_addr !== WR_MIN || app_cmd !== 3'b000 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL calib_first_write: got en=%b addr=%h cmd=%b busy=%b, want 1 %h 000 1",
               app_en, app_addr, app_cmd, busy, WR_MIN);
    end
    wfifo_rcount = '0;
  endtask

  task automatic test_write_burst();
    logic [ADDR_W-1:0] expAddr [4] = '{29'd0, 29'd8, 29'd16, 29'd24};
    wfifo_rcount = 11'd64;
    wr_bust_len  = 8'd4;
    doReset();
    collect(12, 1'b0, '1);
    vectors++;
    if (addrQ.size() !== 4 || rdenCnt !== 4 || endCnt !== 4) begin
      miscompares++;
      $display("[TB] FAIL write_burst_count: got beats=%0d rden=%0d end=%0d, want 4 4 4",
               addrQ.size(), rdenCnt, endCnt);
    end
    for (int i = 0; i < 4 && i < addrQ.size(); i++) begin
      vectors++;
      if (addrQ[i] !== expAddr[i] || cmdQ[i] !== 3'b000) begin
        miscompares++;
        $display("[TB] FAIL write_burst_addr[%0d]: got %h cmd %b, want %h cmd 000", i, addrQ[i], cmdQ[i], expAddr[i]);
      end
    end
  endtask

  task automatic test_write_stall();
    logic [ADDR_W-1:0] expAddr [4] = '{29'd0, 29'd8, 29'd16, 29'd24};
    wfifo_rcount = 11'd64;
    wr_bust_len  = 8'd4;
    doReset();
    collect(12, 1'b0, ~64'h1C);
    vectors++;
    if (addrQ.size() !== 4 || rdenCnt !== 4 || stallCnt !== 3) begin
      miscompares++;
      $display("[TB] FAIL write_stall_count: got beats=%0d rden=%0d stalls=%0d, want 4 4 3",
               addrQ.size(), rdenCnt, stallCnt);
    end
    for (int i = 0; i < 4 && i < addrQ.size(); i++) begin
      vectors++;
      if (addrQ[i] !== expAddr[i]) begin
        miscompares++;
        $display("[TB] FAIL write_stall_addr[%0d]: got %h, want %h", i, addrQ[i], expAddr[i]);
      end
    end
  endtask

  task automatic test_arbitration();
    logic [ADDR_W-1:0] expAddr [8] = '{29'd0, 29'd8, BANK_OFF + RD_MIN, BANK_OFF + RD_MIN + 29'd8,
                                       29'd16, 29'd24, BANK_OFF + RD_MIN + 29'd16, BANK_OFF + RD_MIN + 29'd24};
    logic [2:0]        expCmd  [8] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000, 3'b001, 3'b001};
    wfifo_rcount = 11'd64;
    rfifo_wcount = 11'd0;
    wr_bust_len  = 8'd2;
    rd_bust_len  = 8'd2;
    doReset();
    collect(12, 1'b1, '1);
    vectors++;
    if (addrQ.size() !== 8 || rdenCnt !== 4) begin
      miscompares++;
      $display("[TB] FAIL arb_count: got beats=%0d rden=%0d, want 8 4", addrQ.size(), rdenCnt);
    end
    for (int i = 0; i < 8 && i < addrQ.size(); i++) begin
      vectors++;
      if (addrQ[i] !== expAddr[i] || cmdQ[i] !== expCmd[i]) begin
        miscompares++;
        $display("[TB] FAIL arb_beat[%0d]: got addr %h cmd %b, want addr %h cmd %b",
                 i, addrQ[i], cmdQ[i], expAddr[i], expCmd[i]);
      end
    end
    wfifo_rcount = '0;
    rfifo_wcount = CNT_W'(RFIFO_DEPTH);
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] expAddr [4] = '{29'd0, 29'd8, 29'd16, 29'd0};
    app_addr_wr_max = 29'd16;
    wfifo_rcount    = 11'd64;
    wr_bust_len     = 8'd4;
    doReset();
    collect(10, 1'b0, '1);
    vectors++;
    if (addrQ.size() !== 4) begin
      miscompares++;
      $display("[TB] FAIL wrap_count: got %0d beats, want 4", addrQ.size());
    end
    for (int i = 0; i < 4 && i < addrQ.size(); i++) begin
      vectors++;
      if (addrQ[i] !== expAddr[i]) begin
        miscompares++;
        $display("[TB] FAIL wrap_addr[%0d]: got %h, want %h", i, addrQ[i], expAddr[i]);
      end
    end
    app_addr_wr_max = WR_MAX;
  endtask

  task automatic test_deferred_load();
    logic [ADDR_W-1:0] expAddr [4] = '{29'd0, 29'd8, 29'd16, 29'd24};
    bit found = 1'b0;
    wfifo_rcount = 11'd64;
    rfifo_wcount = CNT_W'(RFIFO_DEPTH);
    wr_bust_len  = 8'd4;
    rd_bust_len  = 8'd4;
    doReset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (app_en !== 1'b1 || app_addr !== expAddr[i] || wr_bank !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL load_burst[%0d]: got en=%b addr=%h wr_bank=%b, want 1 %h 0",
                 i, app_en, app_addr, wr_bank, expAddr[i]);
      end
      wr_load = (i == 1);
      rd_load = (i == 2);
      if (i == 2) app_addr_rd_min = 29'h0002100;
    end
    rd_load = 1'b0;
    @(negedge clk);
    vectors++;
    if (app_en !== 1'b0 || wr_bank !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL load_apply_cycle: got en=%b wr_bank=%b, want 0 0", app_en, wr_bank);
    end
    @(negedge clk);
    vectors++;
    if (app_en !== 1'b0 || wr_bank !== 1'b1 || rd_bank !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL load_banks: got en=%b wr_bank=%b rd_bank=%b, want 0 1 0", app_en, wr_bank, rd_bank);
    end
    @(negedge clk);
    vectors++;
    if (app_en !== 1'b1 || app_addr !== BANK_OFF || app_cmd !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL load_bank1_write: got en=%b addr=%h cmd=%b, want 1 %h 000", app_en, app_addr, app_cmd, BANK_OFF);
    end
    wfifo_rcount = '0;
    rfifo_wcount = '0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (app_en && app_cmd == 3'b001) begin
        found = 1'b1;
        vectors++;
        if (app_addr !== 29'h0002100) begin
          miscompares++;
          $display("[TB] FAIL load_read_addr: got %h, want %h", app_addr, 29'h0002100);
        end
      end
    end
    if (!found) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL load_read_timeout: got no read in 20 cycles, want a read at %h", 29'h0002100);
    end
    app_addr_rd_min = RD_MIN;
    rfifo_wcount = CNT_W'(RFIFO_DEPTH);
  endtask

  task automatic test_read_space_reset();
    wfifo_rcount = '0;
    rfifo_wcount = 11'd1020;
    rd_bust_len  = 8'd8;
    doReset();
    collect(8, 1'b1, '1);
    vectors++;
    if (addrQ.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL read_space_1020: got %0d commands, want 0", addrQ.size());
    end
    rfifo_wcount = 11'd1017;
    collect(4, 1'b1, '1);
    vectors++;
    if (addrQ.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL read_space_1017: got %0d commands, want 0", addrQ.size());
    end
    rfifo_wcount = 11'd1016;
    @(negedge clk);
    vectors++;
    if (app_en !== 1'b1 || app_cmd !== 3'b001 || app_addr !== BANK_OFF + RD_MIN) begin
      miscompares++;
      $display("[TB] FAIL read_space_1016: got en=%b cmd=%b addr=%h, want 1 001 %h",
               app_en, app_cmd, app_addr, BANK_OFF + RD_MIN);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if (app_en !== 1'b0 || busy !== 1'b0 || wfifo_rden !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_burst: got en=%b busy=%b rden=%b, want 0 0 0", app_en, busy, wfifo_rden);
    end
    @(negedge clk);
    vectors++;
    if (app_en !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_wait_calib: got en=%b one cycle after reset, want 0", app_en);
    end
    @(negedge clk);
    vectors++;
    if (app_en !== 1'b1 || app_addr !== BANK_OFF + RD_MIN) begin
      miscompares++;
      $display("[TB] FAIL reset_read_restart: got en=%b addr=%h, want 1 %h", app_en, app_addr, BANK_OFF + RD_MIN);
    end
  endtask

  initial begin
    reset               = 1'b1;
    init_calib_complete = 1'b0;
    wr_load             = 1'b0;
    rd_load             = 1'b0;
    app_addr_wr_min     = WR_MIN;
    app_addr_wr_max     = WR_MAX;
    app_addr_rd_min     = RD_MIN;
    app_addr_rd_max     = RD_MAX;
    wr_bust_len         = 8'd4;
    rd_bust_len         = 8'd4;
    wfifo_rcount        = '0;
    rfifo_wcount        = CNT_W'(RFIFO_DEPTH);
    app_rdy             = 1'b1;
    app_wdf_rdy         = 1'b1;

    test_reset();
    test_calib_gate();
    test_write_burst();
    test_write_stall();
    test_arbitration();
    test_wrap();
    test_deferred_load();
    test_read_space_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ddr3_burst_scheduler.md
Name: ddr3_burst_scheduler

Overview:
Sequences the shared DDR3 user interface between the camera write path and the HDMI read path of the frame buffer.
- Drains the write FIFO and refills the read FIFO in fixed-length bursts, arbitrating round-robin.
- Walks write and read addresses between programmable min/max bounds.
- Applies frame-load pulses only at burst boundaries, with ping-pong frame banks.
- Sits between the write/read FIFOs and the DDR3 memory controller, in the 100 MHz controller domain.

Parameters:
ADDR_W, 29, DDR3 user address width
CNT_W, 11, FIFO level counter width
RFIFO_DEPTH, 1024, read FIFO capacity in words
ADDR_STEP, 8, address increment per command (BL8)
BANK_OFFSET, 29'h0400000, address offset of frame bank 1

Ports:
clk  in  1  controller clock (100 MHz)
reset  in  1  synchronous, active-high
init_calib_complete  in  1  DDR3 calibration done
wr_load  in  1  one-cycle pulse, new input frame (already synchronised to clk)
rd_load  in  1  one-cycle pulse, new output frame (already synchronised to clk)
app_addr_wr_min / app_addr_wr_max  in  ADDR_W  write window
app_addr_rd_min / app_addr_rd_max  in  ADDR_W  read window
wr_bust_len / rd_bust_len  in  8  commands per burst (0 treated as 1)
wfifo_rcount  in  CNT_W  words readable in write FIFO
rfifo_wcount  in  CNT_W  words held in read FIFO
app_rdy, app_wdf_rdy  in  1  controller ready for command / write data
app_en  out  1  command valid
app_cmd  out  3  3'b000 write, 3'b001 read
app_addr  out  ADDR_W  command address
app_wdf_wren, app_wdf_end  out  1  write data valid / last beat
wfifo_rden  out  1  pop one word from write FIFO
wr_bank, rd_bank  out  1  active frame bank per path
busy  out  1  burst in progress

Behaviour:
- Reset: synchronous active-high reset is fixed, on one clock.
  - State WAIT_CALIB; all strobes 0; app_cmd=0.
  - wr_addr=app_addr_wr_min, rd_addr=app_addr_rd_min.
  - wr_bank=0, rd_bank=1, last_grant=READ (so write wins first tie), pending flags cleared.
  - Reset mid-burst abandons the burst immediately; no further strobes.
- States: WAIT_CALIB -> IDLE when init_calib_complete=1. IDLE -> WRITE or READ on grant. WRITE/READ -> IDLE when the burst counter reaches its length.
- Requests, evaluated in IDLE only:
  - wr_req = wfifo_rcount >= wr_bust_len.
  - rd_req = rfifo_wcount + rd_bust_len <= RFIFO_DEPTH, computed at CNT_W+1 bits.
  - One request alone: grant it.
  - Both: grant the one opposite last_grant; last_grant updates on grant.
  - Grant consumes the IDLE cycle; the first command can issue on the next cycle.
- WRITE beat, occurring when app_rdy & app_wdf_rdy:
  - app_en=app_wdf_wren=app_wdf_end=wfifo_rden=1, app_cmd=000.
  - app_addr = wr_addr + (wr_bank ? BANK_OFFSET : 0).
  - These strobes are combinational from state and ready; all 0 when ready is low (stall, counter holds).
- READ beat, occurring when app_rdy: app_en=1, app_cmd=001, address formed from rd_addr/rd_bank the same way. Read data returns are not tracked.
- Address advance per accepted beat: next = addr + ADDR_STEP. If next > max, wrap to min. A beat at exactly max is legal.
- busy=1 in WRITE/READ only.
- wr_load: sets wr_pending.
  - Applied on the next IDLE cycle: wr_addr=wr_min, wr_bank toggles, pending clears.
  - A load during a burst is deferred until that burst completes.
- rd_load: sets rd_pending.
  - Applied on the next IDLE cycle: rd_addr=rd_min, rd_bank = ~wr_bank, using the already-updated value if wr_load applies in the same cycle.
- Pending loads apply before arbitration in the same IDLE cycle; that cycle grants nothing.
- init_calib_complete falling in any state returns to WAIT_CALIB after the current beat. Addresses and banks are kept.
- Burst length changes take effect only at the next grant; the length is latched on grant.

Test Plan:
- Calibration gate: reset, wfifo_rcount=64, init_calib_complete=0 for 50 cycles -> app_en stays 0; raise it -> WRITE starts 2 cycles later, first app_addr=0.
- Write burst: wr_bust_len=4, app_rdy=app_wdf_rdy=1 -> 4 consecutive beats at addresses 0, 8, 16, 24, with wfifo_rden pulsed 4 times; app_wdf_rdy low for 3 cycles mid-burst -> beats pause, no duplicated address.
- Arbitration: both requests held, bursts of 2 -> bursts alternate W, R, W, R; app_cmd follows 000, 001 per burst.
- Wrap: wr_min=0, wr_max=16, wr_bust_len=4 -> addresses 0, 8, 16, 0.
- Deferred load: wr_load during the 2nd beat of a 4-beat burst -> the burst completes at 8, 16, 24; next write at BANK_OFFSET+0 with wr_bank=1. rd_load in the same IDLE cycle -> rd_bank=0, rd_addr=rd_min.
- Read space and reset: rfifo_wcount=1020, rd_bust_len=8 -> no read grant; at 1016 -> granted. Reset asserted mid-burst -> next cycle all strobes 0, state WAIT_CALIB.
